stepper_ramp_gen: RTL

Trapezoidal-profile step/direction generator for the stepper-motor path. It accepts one move command (step count, direction, start and cruise half-periods) over a valid/ready handshake, drives `square_wave` with linear acceleration and deceleration, sets `pin1`/`pin2` for direction, and signals completion. It is the command-driven successor stage to the fixed-rate pulse generator. It feeds the motor driver directly, and a motion sequencer sits upstream of it.

---
 rtl/stepper_ramp_gen.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/stepper_ramp_gen.sv
// Trapezoidal step/direction generator: accepts one move command and emits
// square_wave with linear accel/decel of the half-period, then pulses done.
module stepper_ramp_gen #(
    parameter int CNT_W       = 24,
    parameter int STEP_W      = 16,
    parameter int ACCEL_DELTA = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic [CNT_W-1:0]  cmd_start_half,
    input  logic [CNT_W-1:0]  cmd_min_half,
    input  logic              abort,
    output logic              square_wave,
    output logic              pin1,
    output logic              pin2,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_CRUISE,
        S_DECEL,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] DELTA      = CNT_W'(ACCEL_DELTA);
    localparam logic [CNT_W-1:0] HALF_FLOOR = CNT_W'(2);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic [STEP_W-1:0]   steps_done_q, steps_done_d;
    logic [STEP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic [CNT_W-1:0]    start_half_q, start_half_d;
    logic [CNT_W-1:0]    min_half_q, min_half_d;
    logic [CNT_W-1:0]    cur_half_q, cur_half_d;
    logic [CNT_W-1:0]    half_cnt_q, half_cnt_d;
    logic                sq_q, sq_d;
    logic                pin1_q, pin1_d;
    logic                pin2_q, pin2_d;
    logic                abort_hi_q, abort_hi_d;

    logic [CNT_W-1:0]    start_c, min_raw, min_c;
    logic [CNT_W:0]      inc_sum;
    logic [CNT_W-1:0]    half_up, half_up_c, half_dn, half_dn_c;
    logic [STEP_W-1:0]   steps_inc, rem, ramp_inc;
    logic                half_end;

    assign start_c   = (cmd_start_half < HALF_FLOOR) ? HALF_FLOOR : cmd_start_half;
    assign min_raw   = (cmd_min_half < HALF_FLOOR) ? HALF_FLOOR : cmd_min_half;
    assign min_c     = (min_raw > start_c) ? start_c : min_raw;

    assign inc_sum   = {1'b0, cur_half_q} + {1'b0, DELTA};
    assign half_up   = inc_sum[CNT_W] ? '1 : inc_sum[CNT_W-1:0];
    assign half_up_c = (half_up > start_half_q) ? start_half_q : half_up;
    assign half_dn   = (cur_half_q < DELTA) ? '0 : cur_half_q - DELTA;
    assign half_dn_c = (half_dn < min_half_q) ? min_half_q : half_dn;

    assign steps_inc = steps_done_q + STEP_W'(1);
    assign rem       = steps_q - steps_inc;
    assign ramp_inc  = ramp_cnt_q + STEP_W'(1);
    assign half_end  = (half_cnt_q == cur_half_q - CNT_W'(1));

    always_comb begin
        state_d      = state_q;
        steps_d      = steps_q;
        steps_done_d = steps_done_q;
        ramp_cnt_d   = ramp_cnt_q;
        start_half_d = start_half_q;
        min_half_d   = min_half_q;
        cur_half_d   = cur_half_q;
        half_cnt_d   = half_cnt_q;
        sq_d         = sq_q;
        pin1_d       = pin1_q;
        pin2_d       = pin2_q;
        abort_hi_d   = abort_hi_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    steps_d      = cmd_steps;
                    start_half_d = start_c;
                    min_half_d   = min_c;
                    cur_half_d   = start_c;
                    steps_done_d = '0;
                    ramp_cnt_d   = '0;
                    half_cnt_d   = '0;
                    sq_d         = 1'b0;
                    abort_hi_d   = 1'b0;
                    pin1_d       = ~cmd_dir;
                    pin2_d       = cmd_dir;
                    state_d      = (cmd_steps == '0) ? S_DONE : S_ACCEL;
                end
            end
            S_ACCEL, S_CRUISE, S_DECEL: begin
                // Termination is decided in the cycle after the final falling
                // edge, so done lands one edge after the last step completes.
                if ((steps_done_q == steps_q) || (!sq_q && (abort || abort_hi_q))) begin
                    state_d = S_DONE;
                end else begin
                    if (abort) begin
                        abort_hi_d = 1'b1;
                    end
                    if (half_end) begin
                        half_cnt_d = '0;
                        sq_d       = ~sq_q;
                        if (sq_q) begin
                            steps_done_d = steps_inc;
                            if (rem != '0) begin
                                if (state_q == S_ACCEL) begin
                                    ramp_cnt_d = ramp_inc;
                                    if (rem <= ramp_inc) begin
                                        state_d = S_DECEL;
                                    end else begin
                                        cur_half_d = half_dn_c;
                                        if (half_dn_c == min_half_q) begin
                                            state_d = S_CRUISE;
                                        end
                                    end
                                end else if (state_q == S_CRUISE) begin
                                    if (rem <= ramp_cnt_q) begin
                                        state_d    = S_DECEL;
                                        cur_half_d = half_up_c;
                                    end
                                end else begin
                                    cur_half_d = half_up_c;
                                end
                            end
                        end
                    end else begin
                        half_cnt_d = half_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            steps_q      <= '0;
            steps_done_q <= '0;
            ramp_cnt_q   <= '0;
            start_half_q <= '0;
            min_half_q   <= '0;
            cur_half_q   <= '0;
            half_cnt_q   <= '0;
            sq_q         <= 1'b0;
            pin1_q       <= 1'b0;
            pin2_q       <= 1'b0;
            abort_hi_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            steps_q      <= steps_d;
            steps_done_q <= steps_done_d;
            ramp_cnt_q   <= ramp_cnt_d;
            start_half_q <= start_half_d;
            min_half_q   <= min_half_d;
            cur_half_q   <= cur_half_d;
            half_cnt_q   <= half_cnt_d;
            sq_q         <= sq_d;
            pin1_q       <= pin1_d;
            pin2_q       <= pin2_d;
            abort_hi_q   <= abort_hi_d;
        end
    end

    assign square_wave = sq_q;
    assign pin1        = pin1_q;
    assign pin2        = pin2_q;
    assign steps_done  = steps_done_q;
    assign cmd_ready   = (state_q == S_IDLE);
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);

endmodule
